// File: rtl/accum_adder_tree_pkg.sv
// accum_adder_tree_pkg: shared sizing helpers and FSM state type for the accumulating adder tree.
package accum_adder_tree_pkg;

    typedef enum logic {IDLE, ACCUM} state_e;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int levels(input int n);
        return clog2(n);
    endfunction

    // Each level halves the node count, rounding up for an odd leftover.
    function automatic int level_nodes(input int n, input int l);
        int c = n;
        for (int i = 0; i < l; i++) c = (c + 1) / 2;
        return c;
    endfunction

endpackage

// File: rtl/accum_adder_tree_level.sv
// adder_tree_level: one registered reduction stage, pairwise sums with odd leftover passed through,
// carrying valid/first/last alongside the data.
module adder_tree_level #(
    parameter int N_IN = 2,
    parameter int W    = 32
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_IN-1:0][W-1:0]          sum_i,
    input  logic                            valid_i,
    input  logic                            first_i,
    input  logic                            last_i,
    output logic [(N_IN+1)/2-1:0][W-1:0]    sum_o,
    output logic                            valid_o,
    output logic                            first_o,
    output logic                            last_o
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT-1:0][W-1:0] sum_d, sum_q;
    logic valid_q, first_q, last_q;

    for (genvar n = 0; n < N_OUT; n++) begin : g_node
        if (2 * n + 1 < N_IN) begin : g_add
            assign sum_d[n] = sum_i[2*n] + sum_i[2*n+1];
        end else begin : g_pass
            assign sum_d[n] = sum_i[2*n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_i;
            first_q <= first_i;
            last_q  <= last_i;
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = valid_q;
    assign first_o = first_q;
    assign last_o  = last_q;

endmodule

// File: rtl/accum_adder_tree.sv
// accum_adder_tree: pipelined INPUT_NUM-way adder tree feeding a first/last framed group accumulator.
// Define ACCUM_ADDER_TREE_SAT_EN for a saturating (sticky within group) accumulator instead of wrap.
module accum_adder_tree
    import accum_adder_tree_pkg::*;
#(
    parameter int INPUT_NUM = 9,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 48,
    parameter int SIGNED    = 1
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [INPUT_NUM-1:0][IN_WIDTH-1:0]  din,
    input  logic                                mul_valid,
    input  logic                                in_first,
    input  logic                                in_last,
    output logic [OUT_WIDTH-1:0]                dout,
    output logic                                dout_valid,
    output logic                                grp_err
);

    localparam int LEVELS = levels(INPUT_NUM);

    logic [INPUT_NUM-1:0][OUT_WIDTH-1:0] ext;
    logic [OUT_WIDTH-1:0] t_sum;
    logic t_valid, t_first, t_last;

    always_comb begin
        for (int i = 0; i < INPUT_NUM; i++)
            ext[i] = SIGNED != 0 ? OUT_WIDTH'($signed(din[i])) : OUT_WIDTH'(din[i]);
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NI = level_nodes(INPUT_NUM, l);
        localparam int NO = level_nodes(INPUT_NUM, l + 1);
        logic [NI-1:0][OUT_WIDTH-1:0] s_in;
        logic [NO-1:0][OUT_WIDTH-1:0] s_out;
        logic v_in, f_in, l_in, v_out, f_out, l_out;
        if (l == 0) begin : g_src
            assign s_in = ext;
            assign v_in = mul_valid;
            assign f_in = in_first;
            assign l_in = in_last;
        end else begin : g_src
            assign s_in = g_lvl[l-1].s_out;
            assign v_in = g_lvl[l-1].v_out;
            assign f_in = g_lvl[l-1].f_out;
            assign l_in = g_lvl[l-1].l_out;
        end
        adder_tree_level #(.N_IN(NI), .W(OUT_WIDTH)) u_level (
            .clk(clk), .rst(rst), .sum_i(s_in), .valid_i(v_in), .first_i(f_in), .last_i(l_in),
            .sum_o(s_out), .valid_o(v_out), .first_o(f_out), .last_o(l_out)
        );
    end

    if (LEVELS == 0) begin : g_flat
        assign t_sum   = ext[0];
        assign t_valid = mul_valid;
        assign t_first = in_first;
        assign t_last  = in_last;
    end else begin : g_tail
        assign t_sum   = g_lvl[LEVELS-1].s_out[0];
        assign t_valid = g_lvl[LEVELS-1].v_out;
        assign t_first = g_lvl[LEVELS-1].f_out;
        assign t_last  = g_lvl[LEVELS-1].l_out;
    end

    state_e state_q;
    logic [OUT_WIDTH-1:0] acc_q, acc_d, acc_sum, dout_q;
    logic dout_valid_q, grp_err_q, start;

    // A beat in IDLE opens a group even without t_first.
    assign start = state_q == IDLE || t_first;
    assign acc_d = start ? t_sum : acc_sum;

`ifdef ACCUM_ADDER_TREE_SAT_EN
    logic sat_q, carry, ovf;
    logic [OUT_WIDTH-1:0] raw;
    assign {carry, raw} = {1'b0, acc_q} + {1'b0, t_sum};
    assign ovf = SIGNED != 0 ? (acc_q[OUT_WIDTH-1] == t_sum[OUT_WIDTH-1]) && (raw[OUT_WIDTH-1] != acc_q[OUT_WIDTH-1])
                             : carry;
    assign acc_sum = sat_q ? acc_q :
                     !ovf ? raw :
                     SIGNED == 0 ? '1 :
                     acc_q[OUT_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_q <= 1'b0;
        else if (t_valid) sat_q <= !start && (sat_q || ovf);
    end
`else
    assign acc_sum = acc_q + t_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            grp_err_q    <= 1'b0;
        end else begin
            dout_valid_q <= t_valid && t_last;
            grp_err_q    <= t_valid && t_first && state_q == ACCUM;
            if (t_valid) begin
                acc_q   <= acc_d;
                state_q <= t_last ? IDLE : ACCUM;
                if (t_last) dout_q <= acc_d;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign grp_err    = grp_err_q;

endmodule

// File: tb/tb_accum_adder_tree.sv
// tb_accum_adder_tree: scoreboard bench driving a signed 48-bit and an unsigned 36-bit instance with shared stimulus.
module tb_accum_adder_tree;

    localparam int N = 9;
    localparam int LAT = 5;
    localparam longint MASK_A = (longint'(1) <<< 48) - 1;
    localparam longint MASK_B = (longint'(1) <<< 36) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0][31:0] din = '0;
    logic mul_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [47:0] dout_a;
    logic [35:0] dout_b;
    logic dout_valid_a, dout_valid_b, grp_err_a, grp_err_b;

    accum_adder_tree #(.INPUT_NUM(N), .IN_WIDTH(32), .OUT_WIDTH(48), .SIGNED(1)) u_a (
        .clk(clk), .rst(rst), .din(din), .mul_valid(mul_valid), .in_first(in_first), .in_last(in_last),
        .dout(dout_a), .dout_valid(dout_valid_a), .grp_err(grp_err_a)
    );

    accum_adder_tree #(.INPUT_NUM(N), .IN_WIDTH(32), .OUT_WIDTH(36), .SIGNED(0)) u_b (
        .clk(clk), .rst(rst), .din(din), .mul_valid(mul_valid), .in_first(in_first), .in_last(in_last),
        .dout(dout_b), .dout_valid(dout_valid_b), .grp_err(grp_err_b)
    );

    always #5 clk = ~clk;

    typedef struct {longint a; longint b; int cyc;} exp_t;
    exp_t dq[$];
    int eq[$];
    int ecount = 0;
    int n_cmp = 0, n_bad = 0;
    bit open = 0, sat_a = 0, sat_b = 0;
    longint acc_a = 0, acc_b = 0, last_a = 0, last_b = 0;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, ecount, act, exp);
        end
    endtask

    task automatic fold(inout longint acc, inout bit sat, input longint x, input int w, input bit sgn);
`ifdef ACCUM_ADDER_TREE_SAT_EN
        longint hi, lo;
        hi = sgn ? (longint'(1) <<< (w - 1)) - 1 : (longint'(1) <<< w) - 1;
        lo = sgn ? -(longint'(1) <<< (w - 1)) : 0;
        if (!sat) begin
            acc += x;
            if (acc > hi) begin acc = hi; sat = 1; end
            else if (acc < lo) begin acc = lo; sat = 1; end
        end
`else
        acc += x;
        sat = 0;
`endif
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < N; i++) din[i] = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with din already set; the beat is sampled on the next posedge.
    task automatic issue(input bit f, input bit l);
        longint sa = 0, sb = 0;
        for (int i = 0; i < N; i++) begin
            sa += longint'($signed(din[i]));
            sb += longint'(din[i]);
        end
        if (open && f) eq.push_back(ecount + LAT);
        if (!open || f) begin
            acc_a = sa; acc_b = sb; sat_a = 0; sat_b = 0;
        end else begin
            fold(acc_a, sat_a, sa, 48, 1'b1);
            fold(acc_b, sat_b, sb, 36, 1'b0);
        end
        open = !l;
        if (l) dq.push_back('{acc_a, acc_b, ecount + LAT});
        mul_valid = 1'b1; in_first = f; in_last = l;
        @(negedge clk);
        mul_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    always @(negedge clk) begin
        bit ev, ee;
        exp_t e;
        if (!rst) begin
            ev = dq.size() != 0 && dq[0].cyc == ecount;
            ee = eq.size() != 0 && eq[0] == ecount;
            if (ev || dout_valid_a || dout_valid_b) begin
                chk("dout_valid_a", longint'(dout_valid_a), longint'(ev));
                chk("dout_valid_b", longint'(dout_valid_b), longint'(ev));
            end
            if (ev) begin
                e = dq.pop_front();
                chk("dout_a", longint'(dout_a), e.a & MASK_A);
                chk("dout_b", longint'(dout_b), e.b & MASK_B);
                last_a = e.a & MASK_A;
                last_b = e.b & MASK_B;
            end
            if (ee || grp_err_a || grp_err_b) begin
                chk("grp_err_a", longint'(grp_err_a), longint'(ee));
                chk("grp_err_b", longint'(grp_err_b), longint'(ee));
            end
            if (ee) void'(eq.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        chk("rst_dout_a", longint'(dout_a), 0);
        chk("rst_dout_b", longint'(dout_b), 0);
        chk("rst_dv_a", longint'(dout_valid_a), 0);
        chk("rst_dv_b", longint'(dout_valid_b), 0);
        chk("rst_err_a", longint'(grp_err_a), 0);
        chk("rst_err_b", longint'(grp_err_b), 0);
        rst = 1'b0;
        idle(2);
        set_all(3); issue(1, 1);
        idle(8);
        set_all(3); issue(1, 0); set_all(4); issue(0, 0); set_all(8); issue(0, 1);
        idle(8);
        set_all(3); issue(1, 0); idle(2); set_all(4); issue(0, 0); idle(2); set_all(8); issue(0, 1);
        idle(8);
        set_all(32'hFFFF_FFFF); issue(1, 1);
        idle(8);
        set_all(1); issue(1, 1); set_all(2); issue(1, 1); set_all(3); issue(1, 1);
        idle(8);
        set_all(5); issue(1, 0); issue(0, 0); set_all(1); issue(1, 1);
        idle(8);
        set_all(32'hFFFF_FFFF); issue(1, 0); issue(0, 0); issue(0, 0); issue(0, 1);
        idle(8);
        set_all(7); issue(1, 0); issue(0, 0); issue(0, 1);
        rst = 1'b1;
        dq.delete(); eq.delete(); open = 0;
        idle(3);
        rst = 1'b0;
        idle(8);
        set_all(2); issue(0, 0); set_all(6); issue(0, 1);
        idle(8);
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) din[i] = $urandom;
            issue($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        set_all(9); issue(0, 1);
        idle(12);
        chk("dq_drained", longint'(dq.size()), 0);
        chk("eq_drained", longint'(eq.size()), 0);
        chk("hold_a", longint'(dout_a), last_a);
        chk("hold_b", longint'(dout_b), last_b);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
